// File: rtl/seq_restoring_divider.sv
// Iterative restoring divider: quotient = (dividend << FRAC_BITS) / divisor,
// one quotient bit per cycle, with saturation and valid/ready handshakes.

module full_subtractor #(
  parameter int SUBTRACTOR_WIDTH = 17
) (
  input  logic [SUBTRACTOR_WIDTH-1:0] a_i,
  input  logic [SUBTRACTOR_WIDTH-1:0] b_i,
  input  logic                        borrow_in_i,
  output logic [SUBTRACTOR_WIDTH-1:0] diff_o,
  output logic                        borrow_out_o
);
  assign {borrow_out_o, diff_o} = {1'b0, a_i} - {1'b0, b_i}
                                  - {{SUBTRACTOR_WIDTH{1'b0}}, borrow_in_i};
endmodule

module seq_restoring_divider #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  overflow,
  output logic                  div_by_zero
);
  localparam int N  = DATA_WIDTH + FRAC_BITS;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                state_q, state_d;
  logic [N-1:0]          num_q, num_d;
  logic [N-1:0]          quo_q, quo_d;
  logic [DATA_WIDTH:0]   rem_q, rem_d;
  logic [DATA_WIDTH-1:0] div_q, div_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] quotient_q, quotient_d;
  logic [DATA_WIDTH-1:0] remainder_q, remainder_d;
  logic                  overflow_q, overflow_d;
  logic                  dbz_q, dbz_d;

  logic [DATA_WIDTH:0]   sub_a, sub_b, trial;
  logic                  borrow;
  logic [N-1:0]          quo_next;
  logic [DATA_WIDTH:0]   rem_next;

  // Clamp the N-bit raw quotient to DATA_WIDTH bits; MSB of result is the overflow flag.
  function automatic logic [DATA_WIDTH:0] saturate(input logic [N-1:0] raw);
    if (raw[N-1:DATA_WIDTH] != '0)
      return {1'b1, {DATA_WIDTH{1'b1}}};
    else
      return {1'b0, raw[DATA_WIDTH-1:0]};
  endfunction

  assign sub_a = {rem_q[DATA_WIDTH-1:0], num_q[N-1]};
  assign sub_b = {1'b0, div_q};

  full_subtractor #(.SUBTRACTOR_WIDTH(DATA_WIDTH + 1)) u_sub (
    .a_i          (sub_a),
    .b_i          (sub_b),
    .borrow_in_i  (1'b0),
    .diff_o       (trial),
    .borrow_out_o (borrow)
  );

  assign quo_next = {quo_q[N-2:0], ~borrow};
  assign rem_next = borrow ? sub_a : trial;

  always_comb begin
    state_d     = state_q;
    num_d       = num_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    div_d       = div_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    overflow_d  = overflow_q;
    dbz_d       = dbz_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          num_d = {dividend, {FRAC_BITS{1'b0}}};
          div_d = divisor;
          rem_d = '0;
          quo_d = '0;
          cnt_d = CW'(N);
          if (divisor == '0) begin
            state_d     = DONE;
            quotient_d  = '1;
            remainder_d = '0;
            overflow_d  = 1'b0;
            dbz_d       = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rem_d = rem_next;
        num_d = num_q << 1;
        quo_d = quo_next;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          // Result and flags are latched here so they stay constant through DONE.
          state_d                  = DONE;
          {overflow_d, quotient_d} = saturate(quo_next);
          remainder_d              = rem_next[DATA_WIDTH-1:0];
          dbz_d                    = 1'b0;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      quotient_q  <= '0;
      remainder_q <= '0;
      overflow_q  <= 1'b0;
      dbz_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      overflow_q  <= overflow_d;
      dbz_q       <= dbz_d;
      cnt_q       <= cnt_d;
    end
  end

  // Working datapath needs no reset: it is fully reloaded on every accept.
  always_ff @(posedge clk) begin
    num_q <= num_d;
    quo_q <= quo_d;
    rem_q <= rem_d;
    div_q <= div_d;
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign overflow    = overflow_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Randomised bench for seq_restoring_divider against an arithmetic reference model.

module tb_seq_restoring_divider;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        overflow;
  logic        div_by_zero;

  int errs   = 0;
  int checks = 0;

  seq_restoring_divider #(.DATA_WIDTH(16), .FRAC_BITS(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .overflow    (overflow),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [15:0] dd, input logic [15:0] dv,
                       output logic [15:0] q, output logic [15:0] r,
                       output logic ovf, output logic dz);
    longint num, qq, rr;
    num = longint'(dd) * 256;
    if (dv == 16'd0) begin
      q = 16'hFFFF; r = 16'd0; ovf = 1'b0; dz = 1'b1;
    end else begin
      qq = num / longint'(dv);
      rr = num % longint'(dv);
      dz = 1'b0;
      r  = 16'(rr);
      if (qq > 65535) begin q = 16'hFFFF; ovf = 1'b1; end
      else            begin q = 16'(qq);  ovf = 1'b0; end
    end
  endtask

  // Accept one operand pair, wait for the result, check it, then hold/release.
  task automatic run_op(input logic [15:0] dd, input logic [15:0] dv, input int hold);
    logic [15:0] eq, er;
    logic        eo, ez;
    int          cyc;
    model(dd, dv, eq, er, eo, ez);
    cyc = 0;
    while (!in_ready && cyc < 100) begin @(posedge clk); #1; cyc++; end
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    in_valid = 1'b1; dividend = dd; divisor = dv; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = 16'($urandom); divisor = 16'($urandom);
    cyc = 0;
    while (!out_valid && cyc < 100) begin @(posedge clk); #1; cyc++; end
    chk("out_valid", 32'(out_valid), 32'd1);
    // Edges after the accepting edge: 24 for a real divide, none for divide-by-zero.
    chk("latency", 32'(cyc), (dv == 16'd0) ? 32'd0 : 32'd24);
    chk("quotient", 32'(quotient), 32'(eq));
    chk("remainder", 32'(remainder), 32'(er));
    chk("overflow", 32'(overflow), 32'(eo));
    chk("div_by_zero", 32'(div_by_zero), 32'(ez));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_q", {quotient, remainder}, {eq, er});
      chk("hold_flags", {30'd0, overflow, div_by_zero}, {30'd0, eo, ez});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release_valid", 32'(out_valid), 32'd0);
    chk("release_in_ready", 32'(in_ready), 32'd1);
    chk("retain_q", {quotient, remainder}, {eq, er});
  endtask

  initial begin
    logic [15:0] rd, rv;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_outputs", {quotient, remainder}, 32'd0);
    chk("rst_flags", {30'd0, overflow, div_by_zero}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    run_op(16'd1, 16'd4, 0);         // 0x0040
    run_op(16'd100, 16'd7, 0);       // 0x0E49 rem 1
    run_op(16'h1000, 16'd1, 0);      // saturates
    run_op(16'h1234, 16'd0, 0);      // divide by zero
    run_op(16'd200, 16'd3, 10);      // long backpressure
    run_op(16'd0, 16'd5, 1);         // zero dividend
    run_op(16'h00FF, 16'd1, 0);      // exact shift, largest non-overflowing
    run_op(16'hFFFF, 16'hFFFF, 0);

    // Reset in the middle of a calculation aborts it with no result shown.
    in_valid = 1'b1; dividend = 16'hFFFF; divisor = 16'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_q", {quotient, remainder}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_op(16'hFFFF, 16'd3, 0);

    for (int n = 0; n < 40; n++) begin
      rd = 16'($urandom);
      case ($urandom_range(0, 4))
        0:       rv = 16'd0;
        1, 2:    rv = 16'($urandom_range(1, 255));
        default: rv = 16'($urandom);
      endcase
      if ($urandom_range(0, 3) == 0) rd = 16'($urandom_range(0, 255));
      run_op(rd, rv, $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
